// File: rtl/qdec_pkg.sv
// Shared encodings for the quadrature decoder: phase states, FSM states,
// direction constants and the single-step transition classifier.
package qdec_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } phase_t;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } qdec_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_UP   = 2'd1,
    TR_DN   = 2'd2,
    TR_ERR  = 2'd3
  } trans_t;

  // Successor of a phase state in the up direction 00->01->11->10->00.
  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      S00:     next_up = S01;
      S01:     next_up = S11;
      S11:     next_up = S10;
      default: next_up = S00;
    endcase
  endfunction

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)               classify = TR_NONE;
    else if (cur == next_up(prev)) classify = TR_UP;
    else if (prev == next_up(cur)) classify = TR_DN;
    else                           classify = TR_ERR;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Per-phase input conditioner: SYNC_STAGES-deep synchronizer, plus an
// optional stability filter when QDEC_FILTER_EN is defined.
module quad_sync #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
  , parameter int unsigned FILT_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
  end

`ifdef QDEC_FILTER_EN
  localparam int unsigned FCNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_CYCLES - 1);

  logic [FCNT_W-1:0] fcnt_q;
  logic              filt_q;

  // Filtered bit flips on the FILT_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_LAST) begin
      fcnt_q <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  assign q = filt_q;
`else
  assign q = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature (2-bit Gray) decoder: position counter, direction, step pulse
// and sticky illegal-jump flag. Optional input filter via QDEC_FILTER_EN.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [CNT_W-1:0] position,
  output logic             dir,
  output logic             step,
  output logic             err
);

`ifdef QDEC_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  // Input pipeline depth after reset; prev is only trusted once it has filled.
  localparam int unsigned PRIME_DEPTH = SYNC_STAGES + (FILT_EN ? FILT_CYCLES : 0);
  localparam int unsigned PCNT_W      = $clog2(PRIME_DEPTH + 1);

  qdec_state_t       state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              a_s, b_s;
  logic [1:0]        s, prev_q, prev_d;
  logic [CNT_W-1:0]  pos_d;
  logic              dir_d, step_d, err_d;

  quad_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILT_CYCLES(FILT_CYCLES)
`endif
  ) u_sync_a (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (a_in),
    .q    (a_s)
  );

  quad_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILT_CYCLES(FILT_CYCLES)
`endif
  ) u_sync_b (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (b_in),
    .q    (b_s)
  );

  assign s = {a_s, b_s};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNPRIMED;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next state: leave UNPRIMED once the sampled s reflects the real pins.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      UNPRIMED: begin
        if (pcnt_q == PCNT_W'(PRIME_DEPTH)) state_d = TRACK;
        else                                pcnt_d  = pcnt_q + PCNT_W'(1);
      end
      TRACK:   ;
      default: state_d = UNPRIMED;
    endcase
  end

  // Output decode; clr wins over a same-cycle step but step/dir still report it.
  always_comb begin
    prev_d = s;
    pos_d  = position;
    dir_d  = dir;
    step_d = 1'b0;
    err_d  = err;
    if (state_q == TRACK) begin
      case (classify(prev_q, s))
        TR_UP: begin
          pos_d  = position + CNT_W'(1);
          dir_d  = DIR_UP;
          step_d = 1'b1;
        end
        TR_DN: begin
          pos_d  = position - CNT_W'(1);
          dir_d  = DIR_DN;
          step_d = 1'b1;
        end
        TR_ERR:  err_d = 1'b1;
        default: ;
      endcase
    end
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end
  end

  // Output and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= 2'b00;
      position <= '0;
      dir      <= 1'b0;
      step     <= 1'b0;
      err      <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      position <= pos_d;
      dir      <= dir_d;
      step     <= step_d;
      err      <= err_d;
    end
  end

endmodule
